serial_alu: RTL

//  Parametrised bit-serial ALU: latches two WIDTH-bit operands and an opcode, then

---
 rtl/alu_pkg.sv | 33 +++
 rtl/serial_alu_if.sv | 28 ++
 rtl/alu_bit_slice.sv | 32 +++
 rtl/serial_alu.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU.
package alu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      ADD  = 3'd0,
      SUB  = 3'd1,
      AND  = 3'd2,
      OR   = 3'd3,
      XOR  = 3'd4,
      NAND = 3'd5,
      NOR  = 3'd6,
      INC  = 3'd7
   } op_e;

   // Raw state encodings; the enum below names the same values.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // Only adder-based opcodes own the carry flip-flop.
   function automatic logic is_arith(input op_e op);
      return (op == ADD) || (op == SUB) || (op == INC);
   endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle between a requester and the bit-serial ALU.
interface serial_alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             start;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             sbit;
   logic             sbit_vld;

   modport master (
      output start, op, a, b,
      input  busy, done, result, carry, zero, sbit, sbit_vld
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, carry, zero, sbit, sbit_vld
   );
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: full adder plus bitwise logic.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   input  op_e  op,
   output logic r,
   output logic cout
);

   logic b_eff;
   logic sum;

   // SUB adds the inverted operand; INC relies on b already forced to 0.
   always_comb begin
      b_eff = (op == SUB) ? ~b : b;
      sum   = a ^ b_eff ^ cin;
      cout  = (a & b_eff) | (cin & (a ^ b_eff));
      r     = sum;
      case (op)
         AND:     r = a & b;
         OR:      r = a | b;
         XOR:     r = a ^ b;
         NAND:    r = ~(a & b);
         NOR:     r = ~(a | b);
         default: r = sum;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: latches operands, evaluates one bit per clock LSB-first.
//
//  state | meaning
//  IDLE  | waiting for start; flags and result held
//  RUN   | one result bit per clock, WIDTH clocks
//  DONE  | done pulse cycle; start here chains the next operation
module serial_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic         clk,
   input  logic         rst,
   serial_alu_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   op_e              op_q, op_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             sbit_q, sbit_d;
   logic             vld_q, vld_d;

   logic             accept;
   logic             slice_r;
   logic             slice_cout;
   logic [WIDTH-1:0] res_next;
   op_e              op_in;

   alu_bit_slice u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .r    (slice_r),
      .cout (slice_cout)
   );

   assign op_in    = op_e'(bus.op);
   assign accept   = bus.start && (state_q != ST_RUN);
   assign res_next = {slice_r, res_q[WIDTH-1:1]};

   // Next-state: shift one bit per RUN cycle; accept overrides in IDLE/DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      sbit_d  = 1'b0;
      vld_d   = 1'b0;

      case (state_q)
         ST_RUN: begin
            res_d  = res_next;
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            sbit_d = slice_r;
            vld_d  = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (is_arith(op_q)) begin
               carry_d = slice_cout;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               zero_d  = (res_next == '0);
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         a_d     = bus.a;
         b_d     = (op_in == INC) ? '0 : bus.b;
         op_d    = op_in;
         res_d   = '0;
         carry_d = (op_in == SUB) || (op_in == INC);
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= ADD;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
         sbit_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
         sbit_q  <= sbit_d;
         vld_q   <= vld_d;
      end
   end

   assign bus.busy     = (state_q == ST_RUN);
   assign bus.done     = done_q;
   assign bus.result   = res_q;
   assign bus.carry    = carry_q;
   assign bus.zero     = zero_q;
   assign bus.sbit     = sbit_q;
   assign bus.sbit_vld = vld_q;

endmodule
